// File: rtl/hdr_tone_pack_if.sv
// hdr_tone_pack_if: valid/ready packet stream (data, sop, eop) with master/slave views
interface hdr_tone_pack_if #(
  parameter int W = 24
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         sop;
  logic         eop;
  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/hdr_tone_pack.sv
// hdr_tone_pack: HDR tone compression to 8-bit RGB with packet-safe show-ahead output FIFO; statistics counters enabled by HDR_TONE_PACK_STATS_EN
module hdr_tone_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  hdr_tone_pack_if.slave  asi_snk,
  input  logic [5:0]      shift_i,
  input  logic            clr_i,
  hdr_tone_pack_if.master aso_src,
  output logic            overflow_o,
  output logic [15:0]     frame_cnt_o,
  output logic [15:0]     drop_cnt_o
);
  localparam int CW = DATA_WIDTH + 2;
  localparam int YW = DATA_WIDTH + 3;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] NEAR = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  logic [2:0][CW-1:0] w_x;
  logic [YW-1:0]      w_rnd;
  logic [2:0][YW-1:0] r_y;
  logic [2:0][7:0]    r_c;
  logic               r_v1, r_sop1, r_eop1;
  logic               r_v2, r_sop2, r_eop2;
  logic [25:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [AW:0]        r_cnt, w_avail;
  logic               w_pop, w_wr, w_eop, w_trunc, w_near, w_room;
  logic               r_ovf;
  state_t             r_state, w_next;

  assign w_x           = asi_snk.data;
  assign asi_snk.ready = 1'b1;
  assign w_rnd         = (shift_i == 6'd0) ? '0 : YW'(1) << (shift_i - 6'd1);

  // Stage 1: round-to-nearest right shift; sop/eop qualified by valid
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_y    <= '0;
      r_v1   <= 1'b0;
      r_sop1 <= 1'b0;
      r_eop1 <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) r_y[i] <= (YW'(w_x[i]) + w_rnd) >> shift_i;
      r_v1   <= asi_snk.valid;
      r_sop1 <= asi_snk.valid & asi_snk.sop;
      r_eop1 <= asi_snk.valid & asi_snk.eop;
    end

  // Stage 2: saturate each channel to 8 bits
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_c    <= '0;
      r_v2   <= 1'b0;
      r_sop2 <= 1'b0;
      r_eop2 <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) r_c[i] <= (r_y[i] > YW'(255)) ? 8'hFF : r_y[i][7:0];
      r_v2   <= r_v1;
      r_sop2 <= r_sop1;
      r_eop2 <= r_eop1;
    end

  // Occupancy seen by this cycle's write once the concurrent pop is accounted for;
  // a non-eop write that would leave only one free slot closes the packet early
  assign w_pop   = aso_src.ready & (r_cnt != '0);
  assign w_avail = r_cnt - (AW+1)'(w_pop);
  assign w_near  = w_avail >= NEAR;
  assign w_room  = w_avail != FULL;

  // Packet framing FSM: decide write, forced eop and truncation for the stage-2 pixel
  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_eop   = r_eop2;
    w_trunc = 1'b0;
    if (r_v2)
      case (r_state)
        IDLE:
          if (r_sop2) begin
            if (!w_room) begin
              w_trunc = 1'b1;
              w_next  = r_eop2 ? IDLE : DROP;
            end else begin
              w_wr = 1'b1;
              if (!r_eop2 && w_near) begin
                w_eop   = 1'b1;
                w_trunc = 1'b1;
                w_next  = DROP;
              end else w_next = r_eop2 ? IDLE : PASS;
            end
          end
        PASS: begin
          w_wr = 1'b1;
          if (r_eop2) w_next = IDLE;
          else if (w_near) begin
            w_eop   = 1'b1;
            w_trunc = 1'b1;
            w_next  = DROP;
          end
        end
        DROP:    if (r_eop2) w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end

  // FSM state and sticky overflow; clear beats a same-cycle truncation
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ovf   <= ~clr_i & (r_ovf | w_trunc);
    end

  // FIFO storage (no reset needed: the head is masked while empty)
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= {r_sop2, w_eop, r_c};

  // FIFO pointers and occupancy; simultaneous write and pop both apply
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    end

  assign aso_src.valid = r_cnt != '0;
  assign {aso_src.sop, aso_src.eop, aso_src.data} = aso_src.valid ? r_mem[r_rp] : 26'h0;
  assign overflow_o    = r_ovf;

`ifdef HDR_TONE_PACK_STATS_EN
  logic [15:0] r_frame_cnt, r_drop_cnt;
  logic        w_enter_drop;

  assign w_enter_drop = (w_next == DROP) && (r_state != DROP);

  // Saturating frame/drop statistics; clear has priority over increments
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (clr_i) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_wr && w_eop && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_enter_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

  assign frame_cnt_o = r_frame_cnt;
  assign drop_cnt_o  = r_drop_cnt;
`else
  assign frame_cnt_o = 16'h0;
  assign drop_cnt_o  = 16'h0;
`endif
endmodule

// File: tb/tb_hdr_tone_pack.sv
// tb_hdr_tone_pack: randomized self-checking bench against a queue-based packet model
module tb_hdr_tone_pack;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = DW + 2;
`ifdef HDR_TONE_PACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr_i = 1'b0;
  logic [5:0]  shift_i = 6'd0;
  logic        overflow_o;
  logic [15:0] frame_cnt_o, drop_cnt_o;

  hdr_tone_pack_if #(.W(3*CW)) snk ();
  hdr_tone_pack_if #(.W(24))   src ();

  hdr_tone_pack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .asi_snk     (snk),
    .shift_i     (shift_i),
    .clr_i       (clr_i),
    .aso_src     (src),
    .overflow_o  (overflow_o),
    .frame_cnt_o (frame_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v, s, e;
    bit [23:0] d;
  } pix_t;

  pix_t        m1, m2;
  logic [25:0] q[$];
  logic [25:0] popped[$];
  bit          in_frame, dropping, e_ovf;
  int          e_frames, e_drops;
  int          n_chk = 0, n_pass = 0, cyc_n = 0, first_v = -1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] tone(longint unsigned x, int s);
    longint unsigned y;
    y = (s == 0) ? x : (x + (64'd1 << (s - 1))) >> s;
    return (y > 255) ? 8'hFF : y[7:0];
  endfunction

  function automatic logic [CW-1:0] rx();
    return {2'($urandom_range(3)), $urandom};
  endfunction

  task automatic model_reset();
    q.delete();
    m1 = '{0, 0, 0, 0};
    m2 = '{0, 0, 0, 0};
    in_frame = 0; dropping = 0; e_ovf = 0; e_frames = 0; e_drops = 0;
  endtask

  task automatic model_edge();
    int n;
    longint unsigned xr, xg, xb;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (src.ready && q.size() != 0) void'(q.pop_front());
    n = q.size();
    if (m2.v) begin
      if (dropping) dropping = !m2.e;
      else if (in_frame || m2.s) begin
        if (!in_frame && n == DEPTH) begin
          e_ovf = 1;
          if (!m2.e) begin dropping = 1; e_drops++; end
        end else if (!m2.e && n + 1 >= DEPTH - 1) begin
          q.push_back({m2.s, 1'b1, m2.d});
          e_ovf = 1; e_frames++; e_drops++; dropping = 1; in_frame = 0;
        end else begin
          q.push_back({m2.s, m2.e, m2.d});
          if (m2.e) e_frames++;
          in_frame = !m2.e;
        end
      end
    end
    if (clr_i) begin e_ovf = 0; e_frames = 0; e_drops = 0; end
    m2 = m1;
    xr = snk.data[3*CW-1 -: CW];
    xg = snk.data[2*CW-1 -: CW];
    xb = snk.data[CW-1:0];
    m1.v = snk.valid;
    m1.s = snk.valid & snk.sop;
    m1.e = snk.valid & snk.eop;
    m1.d = {tone(xr, int'(shift_i)), tone(xg, int'(shift_i)), tone(xb, int'(shift_i))};
  endtask

  task automatic compare();
    check("valid", 32'(src.valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("data", 32'(src.data), 32'(q[0][23:0]));
      check("sop", 32'(src.sop), 32'(q[0][25]));
      check("eop", 32'(src.eop), 32'(q[0][24]));
    end
    if (src.valid && first_v < 0) first_v = cyc_n;
    if (src.valid && src.ready) popped.push_back({src.sop, src.eop, src.data});
    check("overflow", 32'(overflow_o), 32'(e_ovf));
    check("frame_cnt", 32'(frame_cnt_o), STATS ? 32'(e_frames) : 32'd0);
    check("drop_cnt", 32'(drop_cnt_o), STATS ? 32'(e_drops) : 32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
    cyc_n++;
  endtask

  task automatic drive(bit v, bit s, bit e, logic [CW-1:0] r, logic [CW-1:0] g, logic [CW-1:0] b);
    snk.valid = v; snk.sop = s; snk.eop = e; snk.data = {r, g, b};
  endtask

  task automatic drain(int n);
    src.ready = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    repeat (n) tick();
  endtask

  task automatic frame(int n, int vpct, int rpct, bit rnd, logic [CW-1:0] x);
    int i;
    i = 0;
    while (i < n) begin
      src.ready = ($urandom_range(99) < rpct);
      if (rnd && $urandom_range(9) == 0) shift_i = 6'($urandom_range(DW + 1));
      if ($urandom_range(99) < vpct) begin
        if (rnd) drive(1, i == 0, i == n - 1, rx(), rx(), rx());
        else drive(1, i == 0, i == n - 1, x, x, x);
        i++;
      end else drive(0, 1'($urandom_range(1)), 1'($urandom_range(1)), rx(), rx(), rx());
      tick();
    end
    drive(0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    model_reset();
    drive(0, 0, 0, '0, '0, '0);
    src.ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(src.valid), 0);
    check("rst_data", 32'(src.data), 0);
    check("rst_sop", 32'(src.sop), 0);
    check("rst_eop", 32'(src.eop), 0);
    check("snk_ready", 32'(snk.ready), 1);
    reset_n = 1'b1;

    // Basic 4-pixel frame, latency and rounding
    shift_i = 6'd4;
    popped.delete();
    first_v = -1;
    k = cyc_n;
    frame(4, 100, 100, 0, 34'h0_0000_0F08);
    drain(6);
    check("r031_latency", 32'(first_v - k - 1), 32'd2);
    check("r031_beats", 32'(popped.size()), 32'd4);
    check("r031_first", 32'(popped[0]), 32'h2F1F1F1);
    check("r031_mid", 32'(popped[1]), 32'h0F1F1F1);
    check("r031_last", 32'(popped[3]), 32'h1F1F1F1);

    // Saturation, pass-through and rounding corners
    popped.delete();
    shift_i = 6'd8; drive(1, 1, 1, 34'h3_0000_0000, 34'h3_0000_0000, 34'h3_0000_0000); tick();
    shift_i = 6'd0; drive(1, 1, 1, 34'h7F, 34'h7F, 34'h7F); tick();
    shift_i = 6'd1; drive(1, 1, 1, 34'h17, 34'h17, 34'h17); tick();
    drain(6);
    check("r032_sat", 32'(popped[0]), 32'h3FFFFFF);
    check("r032_zero_shift", 32'(popped[1]), 32'h37F7F7F);
    check("r032_round", 32'(popped[2]), 32'h30C0C0C);

    // Truncation with ready held low
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    shift_i = 6'd0;
    popped.delete();
    frame(40, 100, 0, 0, 34'h55);
    src.ready = 1'b0;
    repeat (3) tick();
    check("r033_overflow", 32'(overflow_o), 1);
    check("r033_drop_cnt", 32'(drop_cnt_o), STATS ? 32'd1 : 32'd0);
    drain(20);
    check("r033_buffered", 32'(popped.size()), 32'd15);
    check("r033_forced_eop", 32'(popped[14][24]), 1);
    frame(5, 100, 100, 0, 34'h20);
    drain(8);
    check("r033_next_frame", 32'(popped.size()), 32'd20);
    check("r033_frame_cnt", 32'(frame_cnt_o), STATS ? 32'd2 : 32'd0);

    // Headless pixels after reset are dropped
    reset_n = 1'b0; model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i == 3, rx(), rx(), rx());
      tick();
    end
    frame(6, 100, 100, 1, '0);
    drain(8);
    check("r034_beats", 32'(popped.size()), 32'd6);
    check("r034_frame_cnt", 32'(frame_cnt_o), STATS ? 32'd1 : 32'd0);

    // Random ready over three 100-pixel frames with mid-frame shift changes
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    popped.delete();
    repeat (3) frame(100, 25, 75, 1, '0);
    drain(30);
    check("r035_beats", 32'(popped.size()), 32'd300);
    check("r035_frame_cnt", 32'(frame_cnt_o), STATS ? 32'd3 : 32'd0);
    check("r035_no_overflow", 32'(overflow_o), 0);

    // Reset mid-frame with six entries buffered
    src.ready = 1'b0;
    shift_i = 6'd3;
    for (int i = 0; i < 6; i++) begin
      drive(1, i == 0, 0, rx(), rx(), rx());
      tick();
    end
    drive(0, 0, 0, '0, '0, '0);
    repeat (2) tick();
    check("r036_buffered", 32'(src.valid), 1);
    reset_n = 1'b0; model_reset();
    #1;
    check("r036_rst_valid", 32'(src.valid), 0);
    check("r036_rst_data", 32'(src.data), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    popped.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, i == 2, rx(), rx(), rx());
      tick();
    end
    frame(8, 100, 50, 1, '0);
    drain(20);
    check("r036_beats", 32'(popped.size()), 32'd8);
    check("r036_first_sop", 32'(popped[0][25]), 1);
    check("r036_last_eop", 32'(popped[7][24]), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
